multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Moore/Mealy FSM that sequences the shared-memory multicycle MIPS datapath (one ALU, one memory
//  port, IR/MDR/A/B/ALUOut registers). Decodes op_code in DECODE, drives per-state control strobes,
//  stalls on a memory ready handshake, flags illegal opcodes, counts retired instructions.
// PARAMETERS
//  CNT_W         32  width of instr_count (wraps modulo 2^CNT_W)
//  ILLEGAL_HALT  1   1: illegal opcode parks in TRAP until reset; 0: TRAP lasts 1 cycle, then FETCH
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      asynchronous, active-high reset
//  op_code      in   6      IR[31:26]; valid from DECODE onward
//  mem_ready    in   1      memory completes current read/write this cycle
//  PCWrite      out  1      unconditional PC load
//  PCWriteCond  out  1      PC load if ALU zero (beq)
//  IorD         out  1      0: mem addr=PC, 1: mem addr=ALUOut
//  MemRead      out  1      memory read request (held until mem_ready)
//  MemWrite     out  1      memory write request (held until mem_ready)
//  IRWrite      out  1      load IR
//  MemtoReg     out  1      0: write-back ALUOut, 1: MDR
//  RegDst       out  1      0: rt, 1: rd
//  RegWrite     out  1      register file write
//  ALUSrcA      out  1      0: PC, 1: A
//  ALUSrcB      out  2      00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  ALUOp        out  2      00 add, 01 sub, 10 funct-decoded
//  PCSource     out  2      00 ALU result, 01 ALUOut, 10 jump target
//  illegal      out  1      high while in TRAP
//  instr_count  out  CNT_W  retired-instruction counter
// BEHAVIOUR
//  State reg 4 bits; rst -> IDLE, instr_count=0. IDLE: every output 0. All outputs are 0 unless listed.
//  IDLE     -> FETCH next clock.
//  FETCH    MemRead=1,IorD=0,ALUSrcA=0,ALUSrcB=01,ALUOp=00; IRWrite=PCWrite=mem_ready (Mealy).
//           stay while !mem_ready; -> DECODE when mem_ready.
//  DECODE   ALUSrcA=0,ALUSrcB=11,ALUOp=00. op 35/43 -> MEMADR; 0 -> RTYPE_EX; 4 -> BEQ_EX;
//           8 -> ADDI_EX; 2 -> JUMP; any other -> TRAP.
//  MEMADR   ALUSrcA=1,ALUSrcB=10,ALUOp=00. op 35 -> MEMRD; op 43 -> MEMWR (op re-sampled, IR stable).
//  MEMRD    MemRead=1,IorD=1; stay while !mem_ready; -> MEMWB.
//  MEMWB    RegWrite=1,MemtoReg=1,RegDst=0 -> FETCH (retire).
//  MEMWR    MemWrite=1,IorD=1; stay while !mem_ready; -> FETCH on mem_ready (retire).
//  RTYPE_EX ALUSrcA=1,ALUSrcB=00,ALUOp=10 -> RTYPE_WB.
//  RTYPE_WB RegWrite=1,RegDst=1,MemtoReg=0 -> FETCH (retire).
//  BEQ_EX   ALUSrcA=1,ALUSrcB=00,ALUOp=01,PCWriteCond=1,PCSource=01 -> FETCH (retire).
//  ADDI_EX  ALUSrcA=1,ALUSrcB=10,ALUOp=00 -> ADDI_WB.
//  ADDI_WB  RegWrite=1,RegDst=0,MemtoReg=0 -> FETCH (retire).
//  JUMP     PCWrite=1,PCSource=10 -> FETCH (retire).
//  TRAP     illegal=1, no writes; ILLEGAL_HALT=1: self-loop; 0: -> FETCH, not counted as retired.
//  Cycle counts (mem_ready=1): lw 5, sw 4, R 4, addi 4, beq 3, j 3; each !mem_ready cycle adds 1.
//  instr_count += 1 on the clock edge leaving a retire state; 2^CNT_W-1 -> 0.
//  MemRead and MemWrite never both 1; RegWrite never 1 outside MEMWB/RTYPE_WB/ADDI_WB.
//  rst mid-instruction: immediate async return to IDLE, outputs 0 same cycle, count cleared.
//  mem_ready outside FETCH/MEMRD/MEMWR is ignored.
// TESTING
//  rst=1 then release -> all outputs 0 during rst and IDLE; FETCH with MemRead=1 one clock later.
//  lw (op 35), mem_ready=1 always -> FETCH,DECODE,MEMADR,MEMRD,MEMWB; instr_count 0->1 after 5 clks.
//  sw (op 43), mem_ready low 3 cycles in MEMWR -> MemWrite held 4 cycles, no RegWrite, sw = 7 clks.
//  op sequence 0,4,8,2 with mem_ready=1 -> 4,3,4,3 cycles, strobes per table, instr_count=4.
//  op 63, ILLEGAL_HALT=1 -> TRAP, illegal=1 for 10+ cycles, count unchanged; =0 -> 1 cycle, FETCH.
//  rst pulse during MEMRD -> IDLE same cycle, MemRead drops, instr_count=0; CNT_W=4: 16 retires -> 0.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
// The controller (master) receives the opcode and memory handshake and
// drives every control strobe plus the retired-instruction counter.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op_code;
    logic             mem_ready;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             MemtoReg;
    logic             RegDst;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic [1:0]       PCSource;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  op_code, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, illegal, instr_count
    );

    modport slave (
        output op_code, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, illegal, instr_count
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/
// write-back for lw, sw, R-type, beq, addi and j on a shared-memory
// datapath, stalls on mem_ready, traps illegal opcodes and counts retires.
// Strobes are decoded from the state register (Moore) except IRWrite and
// PCWrite in FETCH, which follow mem_ready so the IR/PC load coincides
// with the memory completing.
module multicycle_ctrl #(
    parameter int CNT_W        = 32,
    parameter int ILLEGAL_HALT = 1
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_RTYPE_EX = 4'd7,
        S_RTYPE_WB = 4'd8,
        S_BEQ_EX   = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11,
        S_JUMP     = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             retire_s;

    // State and retire counter registers; reset returns to IDLE immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state, retire detection and control strobe decode.
    always_comb begin
        state_d         = state_q;
        retire_s        = 1'b0;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.ALUOp       = 2'b00;
        bus.PCSource    = 2'b00;
        bus.illegal     = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = bus.mem_ready;
                bus.PCWrite = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                bus.ALUSrcB = 2'b11;
                case (bus.op_code)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPE_EX;
                    OP_BEQ:       state_d = S_BEQ_EX;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                // Only lw/sw reach here; the IR still holds the same opcode.
                if (bus.op_code == OP_LW) begin
                    state_d = S_MEMRD;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
                retire_s     = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
                if (bus.mem_ready) begin
                    retire_s = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d  = S_MEMWR;
                end
            end
            S_RTYPE_EX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 2'b10;
                state_d     = S_RTYPE_WB;
            end
            S_RTYPE_WB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
                retire_s     = 1'b1;
                state_d      = S_FETCH;
            end
            S_BEQ_EX: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = 2'b01;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
                retire_s        = 1'b1;
                state_d         = S_FETCH;
            end
            S_ADDI_EX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                state_d     = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                bus.RegWrite = 1'b1;
                retire_s     = 1'b1;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
                retire_s     = 1'b1;
                state_d      = S_FETCH;
            end
            S_TRAP: begin
                bus.illegal = 1'b1;
                if (ILLEGAL_HALT != 0) begin
                    state_d = S_TRAP;
                end else begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Retire counter increments on the edge leaving a retire state, wrapping.
    always_comb begin
        if (retire_s) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    assign bus.instr_count = count_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: two instances share stimulus, one with a
// 32-bit counter and halting trap, one with a 4-bit counter and one-cycle
// trap. Expected strobes come from an instruction-level phase list.
module tb_multicycle_ctrl;
    typedef enum int {
        P_IDLE, P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
        P_RTEX, P_RTWB, P_BEQ, P_ADEX, P_ADWB, P_JUMP, P_TRAP
    } phase_t;

    logic        clk;
    logic        rst;
    logic [5:0]  op_r;
    logic        mr_r;
    int          checks;
    int          failures;
    logic [31:0] cnt0;
    logic [3:0]  cnt1;
    logic [16:0] obs0, obs1;
    logic [5:0]  legal_ops [6];

    multicycle_ctrl_if #(.CNT_W(32)) if0 ();
    multicycle_ctrl_if #(.CNT_W(4))  if1 ();

    assign if0.op_code   = op_r;
    assign if0.mem_ready = mr_r;
    assign if1.op_code   = op_r;
    assign if1.mem_ready = mr_r;

    assign obs0 = {if0.PCWrite, if0.PCWriteCond, if0.IorD, if0.MemRead, if0.MemWrite,
                   if0.IRWrite, if0.MemtoReg, if0.RegDst, if0.RegWrite, if0.ALUSrcA,
                   if0.ALUSrcB, if0.ALUOp, if0.PCSource, if0.illegal};
    assign obs1 = {if1.PCWrite, if1.PCWriteCond, if1.IorD, if1.MemRead, if1.MemWrite,
                   if1.IRWrite, if1.MemtoReg, if1.RegDst, if1.RegWrite, if1.ALUSrcA,
                   if1.ALUSrcB, if1.ALUOp, if1.PCSource, if1.illegal};

    multicycle_ctrl #(.CNT_W(32), .ILLEGAL_HALT(1)) dut0 (.clk(clk), .rst(rst), .bus(if0.master));
    multicycle_ctrl #(.CNT_W(4),  .ILLEGAL_HALT(0)) dut1 (.clk(clk), .rst(rst), .bus(if1.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe table per instruction phase, packed in the same order as obs0/obs1.
    function automatic logic [16:0] exp_vec(input phase_t p, input logic mr);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ill;
        logic [1:0] srcb, aop, psrc;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ill} = 11'd0;
        srcb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (p)
            P_FETCH:  begin mrd = 1'b1; srcb = 2'b01; irw = mr; pcw = mr; end
            P_DECODE: begin srcb = 2'b11; end
            P_MEMADR: begin srca = 1'b1; srcb = 2'b10; end
            P_MEMRD:  begin mrd = 1'b1; iord = 1'b1; end
            P_MEMWB:  begin rw = 1'b1; m2r = 1'b1; end
            P_MEMWR:  begin mwr = 1'b1; iord = 1'b1; end
            P_RTEX:   begin srca = 1'b1; aop = 2'b10; end
            P_RTWB:   begin rw = 1'b1; rdst = 1'b1; end
            P_BEQ:    begin srca = 1'b1; aop = 2'b01; pcwc = 1'b1; psrc = 2'b01; end
            P_ADEX:   begin srca = 1'b1; srcb = 2'b10; end
            P_ADWB:   begin rw = 1'b1; end
            P_JUMP:   begin pcw = 1'b1; psrc = 2'b10; end
            P_TRAP:   begin ill = 1'b1; end
            default:  begin end
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, psrc, ill};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs after the falling edge, check, move past the rising edge.
    task automatic step(input phase_t p0, input phase_t p1, input logic mr, input logic [5:0] op);
        mr_r = mr;
        op_r = op;
        #1;
        chk($sformatf("out0_%s", p0.name()), {15'd0, obs0}, {15'd0, exp_vec(p0, mr)});
        chk($sformatf("out1_%s", p1.name()), {15'd0, obs1}, {15'd0, exp_vec(p1, mr)});
        chk("cnt0", if0.instr_count, cnt0);
        chk("cnt1", {28'd0, if1.instr_count}, {28'd0, cnt1});
        @(negedge clk);
    endtask

    task automatic mem_phase(input phase_t p, input int n, input logic [5:0] op);
        for (int i = 0; i < n; i++) step(p, p, 1'b0, op);
        step(p, p, 1'b1, op);
    endtask

    // Whole instruction; negative stall counts pick 0..2 at random.
    task automatic do_instr(input logic [5:0] op, input int fs, input int ms);
        int nf, nm;
        nf = (fs < 0) ? int'($urandom_range(0, 2)) : fs;
        nm = (ms < 0) ? int'($urandom_range(0, 2)) : ms;
        mem_phase(P_FETCH, nf, 6'($urandom));
        step(P_DECODE, P_DECODE, 1'($urandom), op);
        case (op)
            6'd35: begin
                step(P_MEMADR, P_MEMADR, 1'($urandom), op);
                mem_phase(P_MEMRD, nm, op);
                step(P_MEMWB, P_MEMWB, 1'($urandom), op);
            end
            6'd43: begin
                step(P_MEMADR, P_MEMADR, 1'($urandom), op);
                mem_phase(P_MEMWR, nm, op);
            end
            6'd0: begin
                step(P_RTEX, P_RTEX, 1'($urandom), op);
                step(P_RTWB, P_RTWB, 1'($urandom), op);
            end
            6'd4: step(P_BEQ, P_BEQ, 1'($urandom), op);
            6'd8: begin
                step(P_ADEX, P_ADEX, 1'($urandom), op);
                step(P_ADWB, P_ADWB, 1'($urandom), op);
            end
            6'd2: step(P_JUMP, P_JUMP, 1'($urandom), op);
            default: begin end
        endcase
        cnt0 = cnt0 + 32'd1;
        cnt1 = cnt1 + 4'd1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        cnt0 = 32'd0;
        cnt1 = 4'd0;
        step(P_IDLE, P_IDLE, 1'($urandom), 6'($urandom));
        rst = 1'b0;
        step(P_IDLE, P_IDLE, 1'($urandom), 6'($urandom));
    endtask

    // Illegal opcode: instance 0 parks in TRAP, instance 1 returns to FETCH.
    task automatic do_trap(input logic [5:0] op);
        mem_phase(P_FETCH, 0, 6'($urandom));
        step(P_DECODE, P_DECODE, 1'b1, op);
        for (int i = 0; i < 11; i++) begin
            step(P_TRAP, (i == 0) ? P_TRAP : P_FETCH, 1'b0, op);
        end
        do_reset();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        cnt0      = 32'd0;
        cnt1      = 4'd0;
        rst       = 1'b1;
        op_r      = 6'd0;
        mr_r      = 1'b0;
        legal_ops = '{6'd35, 6'd43, 6'd0, 6'd4, 6'd8, 6'd2};
        @(negedge clk);
        step(P_IDLE, P_IDLE, 1'b1, 6'd35);
        do_reset();

        // lw with no stalls, then sw with three MEMWR stall cycles.
        do_instr(6'd35, 0, 0);
        do_instr(6'd43, 0, 3);

        // R-type, beq, addi, j back to back.
        do_instr(6'd0, 0, 0);
        do_instr(6'd4, 0, 0);
        do_instr(6'd8, 0, 0);
        do_instr(6'd2, 0, 0);
        chk("count_after_six", if0.instr_count, 32'd6);

        // Random legal mix with random memory stalls.
        for (int i = 0; i < 24; i++) begin
            do_instr(legal_ops[$urandom_range(0, 5)], -1, -1);
        end

        // Asynchronous reset while a lw is waiting in MEMRD.
        mem_phase(P_FETCH, 0, 6'd0);
        step(P_DECODE, P_DECODE, 1'b1, 6'd35);
        step(P_MEMADR, P_MEMADR, 1'b1, 6'd35);
        mr_r = 1'b0;
        #1;
        chk("memrd0", {15'd0, obs0}, {15'd0, exp_vec(P_MEMRD, 1'b0)});
        chk("memrd1", {15'd0, obs1}, {15'd0, exp_vec(P_MEMRD, 1'b0)});
        #1;
        rst = 1'b1;
        #1;
        cnt0 = 32'd0;
        cnt1 = 4'd0;
        chk("rst_mid_out0", {15'd0, obs0}, 32'd0);
        chk("rst_mid_out1", {15'd0, obs1}, 32'd0);
        chk("rst_mid_cnt0", if0.instr_count, 32'd0);
        chk("rst_mid_cnt1", {28'd0, if1.instr_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(P_IDLE, P_IDLE, 1'b1, 6'd35);

        // Sixteen retires wrap the 4-bit counter back to zero.
        for (int i = 0; i < 16; i++) begin
            do_instr(legal_ops[$urandom_range(0, 5)], -1, -1);
        end
        #1;
        chk("wrap_cnt1", {28'd0, if1.instr_count}, 32'd0);
        chk("wrap_cnt0", if0.instr_count, 32'd16);

        // Illegal opcodes, both the all-ones case and a random one.
        do_trap(6'd63);
        do_trap(6'($urandom_range(9, 34)));
        do_instr(6'd35, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
